// File: rtl/aqua_pkg.sv
// aqua_pkg: shared result-buffer entry type, forwarding depths and small helpers.
package aqua_pkg;

    typedef struct packed {
        logic        valid;
        logic        wr_en;
        logic [4:0]  rd_buff;
        logic [31:0] data_buff;
    } uv_buff_t;

    localparam int FWD_ALU_DEPTH = 3;
    localparam int FWD_MEM_DEPTH = 2;

    // A stalled write-back port keeps its payload visible but requests nothing.
    function automatic uv_buff_t wb_gate(input uv_buff_t b, input logic stall);
        uv_buff_t r;
        r = b;
        r.valid = b.valid & ~stall;
        r.wr_en = b.wr_en & ~stall;
        return r;
    endfunction

    function automatic logic [1:0] retires(input uv_buff_t b);
        return {1'b0, b.valid & b.wr_en};
    endfunction

endpackage

// File: rtl/fwd_shift_lane.sv
// fwd_shift_lane: DEPTH-slot result shift register with stall hold and stage-1 flush.
module fwd_shift_lane
    import aqua_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     stall_i,
    input  logic     flush_i,
    input  uv_buff_t in_i,
    output uv_buff_t stage_o [DEPTH]
);

    uv_buff_t q [DEPTH];
    uv_buff_t d [DEPTH];
    uv_buff_t cap;

    // wr_en survives only for a valid entry targeting a real register.
    always_comb begin
        cap = in_i;
        cap.wr_en = in_i.valid & in_i.wr_en & (|in_i.rd_buff);
    end

    // Flush beats stall: stage 1 is cleared even while the rest of the lane holds.
    assign d[0] = flush_i ? '0 : stall_i ? q[0] : cap;

    genvar i;
    for (i = 1; i < DEPTH; i++) begin : g_shift
        assign d[i] = stall_i ? q[i] : q[i-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DEPTH; k++) q[k] <= '0;
        end else begin
            q <= d;
        end
    end

    assign stage_o = q;

endmodule

// File: rtl/fwd_result_buffer.sv
// fwd_result_buffer: ALU/BRU/MEM forwarding result pipelines feeding register-file
// write-back, with a running count of retired writes.
module fwd_result_buffer
    import aqua_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  uv_buff_t    i_alu_res_pkg,
    input  uv_buff_t    i_bru_res_pkg,
    input  uv_buff_t    i_mem_res_pkg,
    output uv_buff_t    o_alu_buff_1_pkg,
    output uv_buff_t    o_alu_buff_2_pkg,
    output uv_buff_t    o_alu_buff_3_pkg,
    output uv_buff_t    o_bru_buff_1_pkg,
    output uv_buff_t    o_bru_buff_2_pkg,
    output uv_buff_t    o_bru_buff_3_pkg,
    output uv_buff_t    o_mem_buff_1_pkg,
    output uv_buff_t    o_mem_buff_2_pkg,
    output uv_buff_t    o_wb_alu_pkg,
    output uv_buff_t    o_wb_bru_pkg,
    output uv_buff_t    o_wb_mem_pkg,
    output logic [31:0] o_retire_cnt
);

    uv_buff_t    alu_s [FWD_ALU_DEPTH];
    uv_buff_t    bru_s [FWD_ALU_DEPTH];
    uv_buff_t    mem_s [FWD_MEM_DEPTH];
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [1:0]  retire_n;

    fwd_shift_lane #(.DEPTH(FWD_ALU_DEPTH)) u_alu (
        .clk_i(i_clk), .rst_i(i_rst), .stall_i(i_stall), .flush_i(i_flush),
        .in_i(i_alu_res_pkg), .stage_o(alu_s)
    );

    fwd_shift_lane #(.DEPTH(FWD_ALU_DEPTH)) u_bru (
        .clk_i(i_clk), .rst_i(i_rst), .stall_i(i_stall), .flush_i(i_flush),
        .in_i(i_bru_res_pkg), .stage_o(bru_s)
    );

    fwd_shift_lane #(.DEPTH(FWD_MEM_DEPTH)) u_mem (
        .clk_i(i_clk), .rst_i(i_rst), .stall_i(i_stall), .flush_i(i_flush),
        .in_i(i_mem_res_pkg), .stage_o(mem_s)
    );

    assign o_alu_buff_1_pkg = alu_s[0];
    assign o_alu_buff_2_pkg = alu_s[1];
    assign o_alu_buff_3_pkg = alu_s[2];
    assign o_bru_buff_1_pkg = bru_s[0];
    assign o_bru_buff_2_pkg = bru_s[1];
    assign o_bru_buff_3_pkg = bru_s[2];
    assign o_mem_buff_1_pkg = mem_s[0];
    assign o_mem_buff_2_pkg = mem_s[1];

    assign o_wb_alu_pkg = wb_gate(alu_s[FWD_ALU_DEPTH-1], i_stall);
    assign o_wb_bru_pkg = wb_gate(bru_s[FWD_ALU_DEPTH-1], i_stall);
    assign o_wb_mem_pkg = wb_gate(mem_s[FWD_MEM_DEPTH-1], i_stall);

    assign retire_n = retires(o_wb_alu_pkg) + retires(o_wb_bru_pkg) + retires(o_wb_mem_pkg);
    assign retire_cnt_d = i_stall ? retire_cnt_q : retire_cnt_q + 32'(retire_n);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) retire_cnt_q <= '0;
        else       retire_cnt_q <= retire_cnt_d;
    end

    assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_fwd_result_buffer.sv
// tb_fwd_result_buffer: directed scenarios plus a randomized scoreboard stream.
module tb_fwd_result_buffer;
    import aqua_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_stall, i_flush;
    uv_buff_t    alu_in, bru_in, mem_in;
    uv_buff_t    a1, a2, a3, b1, b2, b3, m1, m2, w_alu, w_bru, w_mem;
    logic [31:0] cnt;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt;
    uv_buff_t    sq [3][$];

    fwd_result_buffer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_alu_res_pkg(alu_in), .i_bru_res_pkg(bru_in), .i_mem_res_pkg(mem_in),
        .o_alu_buff_1_pkg(a1), .o_alu_buff_2_pkg(a2), .o_alu_buff_3_pkg(a3),
        .o_bru_buff_1_pkg(b1), .o_bru_buff_2_pkg(b2), .o_bru_buff_3_pkg(b3),
        .o_mem_buff_1_pkg(m1), .o_mem_buff_2_pkg(m2),
        .o_wb_alu_pkg(w_alu), .o_wb_bru_pkg(w_bru), .o_wb_mem_pkg(w_mem),
        .o_retire_cnt(cnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic uv_buff_t mk(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
        return {v, we, rd, d};
    endfunction

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        i_stall = 1'b0;
        i_flush = 1'b0;
        alu_in = '0;
        bru_in = '0;
        mem_in = '0;
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({a1, a2, a3, b1, b2, b3, m1, m2, w_alu, w_bru, w_mem} !== '0) begin
            bad++;
            $display("FAIL reset_stages got=%h exp=0", {a1, a2, a3, b1, b2, b3, m1, m2, w_alu, w_bru, w_mem});
        end
        total++;
        if (cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
    endtask

    task automatic test_alu_latency;
        uv_buff_t e;
        do_reset();
        e = mk(1, 1, 5, 32'h1234);
        alu_in = e;
        tick();
        alu_in = '0;
        total++;
        if (a1 !== e) begin bad++; $display("FAIL lat_s1 got=%h exp=%h", a1, e); end
        tick();
        total++;
        if (a2 !== e) begin bad++; $display("FAIL lat_s2 got=%h exp=%h", a2, e); end
        tick();
        total++;
        if (a3 !== e) begin bad++; $display("FAIL lat_s3 got=%h exp=%h", a3, e); end
        total++;
        if (w_alu !== e) begin bad++; $display("FAIL lat_wb got=%h exp=%h", w_alu, e); end
        total++;
        if (cnt !== 32'd0) begin bad++; $display("FAIL lat_cnt_early got=%h exp=0", cnt); end
        tick();
        total++;
        if (cnt !== 32'd1) begin bad++; $display("FAIL lat_cnt got=%h exp=1", cnt); end
    endtask

    task automatic test_rd_zero;
        uv_buff_t e;
        do_reset();
        bru_in = mk(1, 1, 0, 32'hABCD);
        e = mk(1, 0, 0, 32'hABCD);
        tick();
        bru_in = '0;
        total++;
        if (b1 !== e) begin bad++; $display("FAIL rd0_s1 got=%h exp=%h", b1, e); end
        tick();
        tick();
        total++;
        if (w_bru !== e) begin bad++; $display("FAIL rd0_wb got=%h exp=%h", w_bru, e); end
        tick();
        tick();
        total++;
        if (cnt !== 32'd0) begin bad++; $display("FAIL rd0_cnt got=%h exp=0", cnt); end
    endtask

    task automatic test_stall;
        uv_buff_t a, e, hold;
        do_reset();
        a = mk(1, 1, 3, 32'hAAAA_0001);
        e = mk(1, 1, 7, 32'hEEEE_0002);
        hold = mk(0, 0, 3, 32'hAAAA_0001);
        alu_in = a;
        tick();
        alu_in = e;
        tick();
        alu_in = '0;
        tick();
        i_stall = 1'b1;
        alu_in = mk(1, 1, 9, 32'h9999);
        #1;
        total++;
        if (w_alu !== hold) begin bad++; $display("FAIL stall_wb got=%h exp=%h", w_alu, hold); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (a2 !== e) begin bad++; $display("FAIL stall_s2 cyc=%0d got=%h exp=%h", k, a2, e); end
            total++;
            if (a3 !== a) begin bad++; $display("FAIL stall_s3 cyc=%0d got=%h exp=%h", k, a3, a); end
            total++;
            if (a1 !== '0) begin bad++; $display("FAIL stall_capture cyc=%0d got=%h exp=0", k, a1); end
            total++;
            if (w_alu.valid !== 1'b0) begin bad++; $display("FAIL stall_wbv cyc=%0d got=%b exp=0", k, w_alu.valid); end
            total++;
            if (cnt !== 32'd0) begin bad++; $display("FAIL stall_cnt cyc=%0d got=%h exp=0", k, cnt); end
        end
        i_stall = 1'b0;
        alu_in = '0;
        #1;
        total++;
        if (w_alu !== a) begin bad++; $display("FAIL stall_release got=%h exp=%h", w_alu, a); end
        tick();
        total++;
        if (w_alu !== e) begin bad++; $display("FAIL stall_late_s3 got=%h exp=%h", w_alu, e); end
        total++;
        if (cnt !== 32'd1) begin bad++; $display("FAIL stall_cnt1 got=%h exp=1", cnt); end
        tick();
        total++;
        if (cnt !== 32'd2) begin bad++; $display("FAIL stall_cnt2 got=%h exp=2", cnt); end
    endtask

    task automatic test_flush;
        uv_buff_t a, b, m, c;
        do_reset();
        a = mk(1, 1, 1, 32'hA1);
        b = mk(1, 1, 2, 32'hB2);
        m = mk(1, 1, 3, 32'hC3);
        c = mk(1, 1, 4, 32'hD4);
        alu_in = a; bru_in = b; mem_in = m;
        tick();
        alu_in = c; bru_in = mk(1, 1, 5, 32'hE5); mem_in = mk(1, 1, 6, 32'hF6);
        i_flush = 1'b1;
        tick();
        total++;
        if ({a1, b1, m1} !== '0) begin bad++; $display("FAIL flush_s1 got=%h exp=0", {a1, b1, m1}); end
        total++;
        if ({a2, b2, m2} !== {a, b, m}) begin bad++; $display("FAIL flush_s2 got=%h exp=%h", {a2, b2, m2}, {a, b, m}); end
        i_flush = 1'b0;
        bru_in = '0; mem_in = '0;
        tick();
        total++;
        if (a1 !== c) begin bad++; $display("FAIL flush_recap got=%h exp=%h", a1, c); end
        i_flush = 1'b1;
        i_stall = 1'b1;
        alu_in = mk(1, 1, 8, 32'h88);
        tick();
        total++;
        if (a1 !== '0) begin bad++; $display("FAIL flushstall_s1 got=%h exp=0", a1); end
        total++;
        if ({a3, b3} !== {a, b}) begin bad++; $display("FAIL flushstall_s3 got=%h exp=%h", {a3, b3}, {a, b}); end
        i_flush = 1'b0;
        i_stall = 1'b0;
        alu_in = '0;
    endtask

    task automatic test_retire_wrap;
        uv_buff_t x, y, z;
        do_reset();
        x = mk(1, 1, 4, 32'h4444);
        y = mk(1, 1, 6, 32'h6666);
        z = mk(1, 1, 9, 32'h9999);
        alu_in = x; bru_in = y;
        tick();
        alu_in = '0; bru_in = '0; mem_in = z;
        tick();
        mem_in = '0;
        tick();
        total++;
        if ({w_alu, w_bru, w_mem} !== {x, y, z}) begin bad++; $display("FAIL wrap_wb got=%h exp=%h", {w_alu, w_bru, w_mem}, {x, y, z}); end
        total++;
        if (cnt !== 32'd0) begin bad++; $display("FAIL wrap_pre got=%h exp=0", cnt); end
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt_q;
        tick();
        total++;
        if (cnt !== 32'h0000_0001) begin bad++; $display("FAIL wrap_cnt got=%h exp=00000001", cnt); end
    endtask

    task automatic test_async_reset;
        uv_buff_t e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            alu_in = mk(1, 1, 5'(k + 1), 32'(k));
            bru_in = mk(1, 1, 5'(k + 2), 32'(k + 100));
            mem_in = mk(1, 1, 5'(k + 3), 32'(k + 200));
            tick();
        end
        total++;
        if (cnt === 32'd0) begin bad++; $display("FAIL arst_prefill got=%h exp=nonzero", cnt); end
        #2;
        i_rst = 1'b1;
        #1;
        total++;
        if ({a1, a2, a3, b1, b2, b3, m1, m2, w_alu, w_bru, w_mem, cnt} !== '0) begin
            bad++;
            $display("FAIL arst_clear got=%h exp=0", {a1, a2, a3, b1, b2, b3, m1, m2, w_alu, w_bru, w_mem, cnt});
        end
        e = mk(1, 1, 12, 32'hCAFE);
        alu_in = e; bru_in = '0; mem_in = '0;
        #1;
        i_rst = 1'b0;
        tick();
        alu_in = '0;
        total++;
        if (a1 !== e) begin bad++; $display("FAIL arst_first_capture got=%h exp=%h", a1, e); end
        total++;
        if (a2 !== '0) begin bad++; $display("FAIL arst_dropped got=%h exp=0", a2); end
    endtask

    task automatic test_stream;
        uv_buff_t ins [3];
        uv_buff_t got [3];
        uv_buff_t e;
        logic drain;
        do_reset();
        exp_cnt = '0;
        for (int l = 0; l < 3; l++) sq[l].delete();
        for (int c = 0; c < 260; c++) begin
            drain = (c >= 240);
            i_stall = !drain && ($urandom_range(0, 4) == 0);
            i_flush = !drain && !i_stall && ($urandom_range(0, 9) == 0);
            for (int l = 0; l < 3; l++)
                ins[l] = drain ? '0 : mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                                         ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                                         $urandom);
            alu_in = ins[0]; bru_in = ins[1]; mem_in = ins[2];
            #1;
            got = '{w_alu, w_bru, w_mem};
            for (int l = 0; l < 3; l++) begin
                if (i_stall) begin
                    total++;
                    if (got[l].valid !== 1'b0) begin bad++; $display("FAIL sb_stall_wbv lane=%0d got=%b exp=0", l, got[l].valid); end
                end else if (got[l].valid) begin
                    total++;
                    if (sq[l].size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra lane=%0d got=%h exp=none", l, got[l]);
                    end else begin
                        e = sq[l].pop_front();
                        if (e.wr_en) exp_cnt++;
                        if (got[l] !== e) begin bad++; $display("FAIL sb_wb lane=%0d got=%h exp=%h", l, got[l], e); end
                    end
                end
            end
            if (!i_stall && !i_flush)
                for (int l = 0; l < 3; l++)
                    if (ins[l].valid)
                        sq[l].push_back(mk(1, ins[l].wr_en && (ins[l].rd_buff != 5'd0), ins[l].rd_buff, ins[l].data_buff));
            tick();
            total++;
            if (cnt !== exp_cnt) begin bad++; $display("FAIL sb_cnt cyc=%0d got=%h exp=%h", c, cnt, exp_cnt); end
        end
        for (int l = 0; l < 3; l++) begin
            total++;
            if (sq[l].size() != 0) begin bad++; $display("FAIL sb_lost lane=%0d got=%0d exp=0", l, sq[l].size()); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_latency();
        test_rd_zero();
        test_stall();
        test_flush();
        test_retire_wrap();
        test_async_reset();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
